// File: rtl/roic_frame_align_ctrl.sv
// Frame-word alignment controller for the ROIC LVDS deserializer (bit-clock domain).
// Optional loss-of-lock monitor with automatic realignment: define ROIC_ALIGN_LOSS_MON_EN.
module roic_frame_align_ctrl #(
   parameter int                DATA_W        = 8,
   parameter logic [DATA_W-1:0] FRAME_PATTERN = 8'hF0,
   parameter int                MATCH_COUNT   = 4,
   parameter int                MAX_SLIP      = 7,
   parameter int                SLIP_WAIT     = 3,
   parameter int                LOSS_COUNT    = 2
) (
   input  logic                            clk_in_int,
   input  logic                            clk_reset,
   input  logic                            align_start,
   input  logic [DATA_W-1:0]               frame_word,
   input  logic                            frame_valid,
   output logic                            bitslip,
   output logic                            aligned,
   output logic                            align_fail,
   output logic [$clog2(MAX_SLIP+1)-1:0]   slip_count,
   output logic                            lock_lost,
   output logic                            busy
);

   localparam int SW = $clog2(MAX_SLIP+1);
   localparam int MW = $clog2(MATCH_COUNT+1);
   localparam int WW = $clog2(SLIP_WAIT+1);

   localparam logic [SW-1:0] SLIP_MAX  = SW'(MAX_SLIP);
   localparam logic [SW-1:0] SLIP_ONE  = SW'(1);
   localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_COUNT);
   localparam logic [MW-1:0] MATCH_ONE = MW'(1);
   localparam logic [WW-1:0] WAIT_LD   = WW'(SLIP_WAIT);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

   if (MATCH_COUNT < 1 || SLIP_WAIT < 1 || LOSS_COUNT < 1) begin : g_param_chk
      $error("roic_frame_align_ctrl: MATCH_COUNT, SLIP_WAIT and LOSS_COUNT must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   slip_q, slip_d;
   logic [MW-1:0]   match_q, match_d, match_inc;
   logic [WW-1:0]   wait_q, wait_d;
   logic            bitslip_q, aligned_q, fail_q, busy_q;
   logic            is_match;

`ifdef ROIC_ALIGN_LOSS_MON_EN
   localparam int LW = $clog2(LOSS_COUNT+1);
   localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_COUNT);
   localparam logic [LW-1:0] LOSS_ONE = LW'(1);
   logic [LW-1:0]   loss_q, loss_d;
   logic            lost_q, lost_d;
`endif

   assign is_match = (frame_word == FRAME_PATTERN);

   always_comb begin
      state_d   = state_q;
      slip_d    = slip_q;
      match_d   = match_q;
      wait_d    = wait_q;
      match_inc = match_q + MATCH_ONE;
`ifdef ROIC_ALIGN_LOSS_MON_EN
      loss_d    = loss_q;
      lost_d    = lost_q;
`endif
      if (align_start) begin
         state_d = S_SETTLE;
         slip_d  = '0;
         match_d = '0;
         wait_d  = WAIT_LD;
`ifdef ROIC_ALIGN_LOSS_MON_EN
         loss_d  = '0;
         lost_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            // wait_q==1 is the last ignored cycle, so SETTLE lasts exactly SLIP_WAIT cycles
            S_SETTLE: begin
               if (wait_q <= WAIT_ONE) begin
                  wait_d  = '0;
                  match_d = '0;
                  state_d = S_CHECK;
               end else begin
                  wait_d  = wait_q - WAIT_ONE;
               end
            end
            S_CHECK: begin
               if (frame_valid) begin
                  if (is_match) begin
                     match_d = match_inc;
                     if (match_inc == MATCH_MAX) state_d = S_LOCKED;
                  end else if (slip_q < SLIP_MAX) begin
                     match_d = '0;
                     slip_d  = slip_q + SLIP_ONE;
                     state_d = S_SLIP;
                  end else begin
                     state_d = S_FAIL;
                  end
               end
            end
            S_SLIP: begin
               wait_d  = WAIT_LD;
               state_d = S_SETTLE;
            end
`ifdef ROIC_ALIGN_LOSS_MON_EN
            S_LOCKED: begin
               if (frame_valid) begin
                  if (is_match) begin
                     loss_d = '0;
                  end else if (loss_q + LOSS_ONE >= LOSS_MAX) begin
                     lost_d  = 1'b1;
                     slip_d  = '0;
                     match_d = '0;
                     loss_d  = '0;
                     wait_d  = WAIT_LD;
                     state_d = S_SETTLE;
                  end else begin
                     loss_d = loss_q + LOSS_ONE;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs are registered copies of the next state so they line up with it cycle-for-cycle.
   always_ff @(posedge clk_in_int or posedge clk_reset) begin
      if (clk_reset) begin
         state_q   <= S_IDLE;
         slip_q    <= '0;
         match_q   <= '0;
         wait_q    <= '0;
         bitslip_q <= 1'b0;
         aligned_q <= 1'b0;
         fail_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef ROIC_ALIGN_LOSS_MON_EN
         loss_q    <= '0;
         lost_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         slip_q    <= slip_d;
         match_q   <= match_d;
         wait_q    <= wait_d;
         bitslip_q <= (state_d == S_SLIP);
         aligned_q <= (state_d == S_LOCKED);
         fail_q    <= (state_d == S_FAIL);
         busy_q    <= (state_d == S_SETTLE) || (state_d == S_CHECK) || (state_d == S_SLIP);
`ifdef ROIC_ALIGN_LOSS_MON_EN
         loss_q    <= loss_d;
         lost_q    <= lost_d;
`endif
      end
   end

   assign bitslip    = bitslip_q;
   assign aligned    = aligned_q;
   assign align_fail = fail_q;
   assign slip_count = slip_q;
   assign busy       = busy_q;
`ifdef ROIC_ALIGN_LOSS_MON_EN
   assign lock_lost  = lost_q;
`else
   assign lock_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_roic_frame_align_ctrl.sv
// Bench for roic_frame_align_ctrl: event-time reference model checked every cycle,
// directed alignment scenarios with literal expectations, then randomized episodes.
module tb_roic_frame_align_ctrl;

   localparam int         DW  = 8;
   localparam logic [7:0] PAT = 8'hF0;
   localparam int         MC  = 4;
   localparam int         MS  = 7;
   localparam int         SW  = 3;
   localparam int         LC  = 2;
`ifdef ROIC_ALIGN_LOSS_MON_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       align_start = 1'b0;
   logic       frame_valid = 1'b0;
   logic [7:0] frame_word = 8'h00;
   logic       bitslip, aligned, align_fail, lock_lost, busy;
   logic [2:0] slip_count;

   always #5 clk = ~clk;

   roic_frame_align_ctrl #(
      .DATA_W(DW), .FRAME_PATTERN(PAT), .MATCH_COUNT(MC),
      .MAX_SLIP(MS), .SLIP_WAIT(SW), .LOSS_COUNT(LC)
   ) dut (
      .clk_in_int (clk),
      .clk_reset  (rst),
      .align_start(align_start),
      .frame_word (frame_word),
      .frame_valid(frame_valid),
      .bitslip    (bitslip),
      .aligned    (aligned),
      .align_fail (align_fail),
      .slip_count (slip_count),
      .lock_lost  (lock_lost),
      .busy       (busy)
   );

   int n_chk = 0;
   int n_pass = 0;

   // reference model: searching/locked/failed flags plus the cycle numbers at which
   // words become comparable and at which a bitslip pulse is due
   bit m_search, m_lock, m_fail, m_lost;
   int m_slips, m_matches, m_losses, m_ready, m_pulse;
   int cyc = 0;

   // environment
   logic [7:0] cur = 8'hF0;
   logic [7:0] script[$];
   bit  rand_fv = 1'b0;
   bit  noise = 1'b0;
   bit  al_drop = 1'b0;
   int  pulses = 0;
   int  first_al = -1;
   int  first_fail = -1;
   int  start_cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
   endtask

   task automatic model_reset();
      m_search = 0; m_lock = 0; m_fail = 0; m_lost = 0;
      m_slips = 0; m_matches = 0; m_losses = 0; m_ready = 0; m_pulse = -1;
   endtask

   // apply the inputs that were sampled at edge number cyc
   task automatic model_step();
      if (align_start) begin
         m_search = 1; m_lock = 0; m_fail = 0; m_lost = 0;
         m_slips = 0; m_matches = 0; m_losses = 0;
         m_ready = cyc + 1 + SW;
      end else if (m_search) begin
         if (frame_valid && cyc >= m_ready) begin
            if (frame_word == PAT) begin
               m_matches++;
               if (m_matches == MC) begin m_search = 0; m_lock = 1; end
            end else begin
               m_matches = 0;
               if (m_slips < MS) begin
                  m_slips++;
                  m_pulse = cyc + 1;
                  m_ready = cyc + 2 + SW;
               end else begin
                  m_search = 0; m_fail = 1;
               end
            end
         end
      end else if (m_lock && LOSS_EN && frame_valid) begin
         if (frame_word == PAT) m_losses = 0;
         else begin
            m_losses++;
            if (m_losses >= LC) begin
               m_lock = 0; m_lost = 1; m_search = 1;
               m_slips = 0; m_matches = 0; m_losses = 0;
               m_ready = cyc + 1 + SW;
            end
         end
      end
   endtask

   task automatic compare();
      chk("bitslip",    bitslip,    (m_pulse == cyc) ? 1 : 0);
      chk("busy",       busy,       m_search);
      chk("aligned",    aligned,    m_lock);
      chk("align_fail", align_fail, m_fail);
      chk("slip_count", slip_count, m_slips);
      chk("lock_lost",  lock_lost,  m_lost);
   endtask

   // one clock: update model for the edge just taken, check, react, drive next inputs
   task automatic tick(input bit st);
      @(negedge clk);
      model_step();
      cyc++;
      compare();
      if (bitslip) begin
         pulses++;
         cur = {cur[6:0], cur[7]};
      end
      if (aligned && first_al < 0) first_al = cyc - start_cyc;
      if (align_fail && first_fail < 0) first_fail = cyc - start_cyc;
      if (!aligned) al_drop = 1'b1;
      if (st) begin
         pulses = 0; first_al = -1; first_fail = -1; start_cyc = cyc;
      end
      align_start = st;
      frame_valid = rand_fv ? ($urandom_range(3) == 0) : (cyc % 4 == 0);
      if (frame_valid && script.size() > 0) frame_word = script.pop_front();
      else if (noise && $urandom_range(7) == 0) frame_word = 8'($urandom);
      else frame_word = cur;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   // align_start on an edge that also carries a frame_valid slot
   task automatic start_aligned();
      while ((cyc + 1) % 4 != 0) tick(1'b0);
      tick(1'b1);
   endtask

   initial begin
      logic [7:0] w;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_bitslip", bitslip, 0);
      chk("rst_aligned", aligned, 0);
      chk("rst_fail",    align_fail, 0);
      chk("rst_slip",    slip_count, 0);
      chk("rst_lost",    lock_lost, 0);
      chk("rst_busy",    busy, 0);
      rst = 1'b0;
      run(5);

      // already aligned
      cur = 8'hF0;
      start_aligned();
      run(24);
      chk("s1_pulses",   pulses, 0);
      chk("s1_lock_lat", first_al, 17);
      chk("s1_slip",     slip_count, 0);
      chk("s1_aligned",  aligned, 1);

      // two bad words while locked
      al_drop = 1'b0;
      script.push_back(8'h0F);
      script.push_back(8'h0F);
      run(48);
      chk("loss_aligned", aligned, 1);
      chk("loss_drop",    al_drop, LOSS_EN ? 1 : 0);
      chk("loss_sticky",  lock_lost, LOSS_EN ? 1 : 0);

      // three-bit offset
      cur = 8'h1E;
      start_aligned();
      run(48);
      chk("s2_pulses",   pulses, 3);
      chk("s2_slip",     slip_count, 3);
      chk("s2_lock_lat", first_al, 41);
      chk("s2_aligned",  aligned, 1);

      // never aligned
      cur = 8'hAA;
      start_aligned();
      run(72);
      chk("s3_pulses",   pulses, 7);
      chk("s3_slip",     slip_count, 7);
      chk("s3_fail_lat", first_fail, 61);
      chk("s3_fail",     align_fail, 1);
      chk("s3_aligned",  aligned, 0);

      // partial match then mismatch
      cur = 8'h78;
      start_aligned();
      repeat (3) script.push_back(8'hF0);
      run(44);
      chk("s4_pulses",   pulses, 1);
      chk("s4_slip",     slip_count, 1);
      chk("s4_lock_lat", first_al, 37);
      chk("s4_aligned",  aligned, 1);

      // restart coinciding with a mismatching word after two slips
      cur = 8'h0F;
      start_aligned();
      run(19);
      tick(1'b1);
      chk("s5_slip_pre", slip_count, 2);
      tick(1'b0);
      chk("s5_bitslip",  bitslip, 0);
      chk("s5_slip",     slip_count, 0);
      chk("s5_busy",     busy, 1);
      run(60);
      chk("s5_aligned",  aligned, 1);
      chk("s5_slip_end", slip_count, 2);

      // randomized episodes
      for (int e = 0; e < 20; e++) begin
         rand_fv = $urandom_range(1);
         noise = 1'b1;
         if ($urandom_range(1) == 1) begin
            w = PAT;
            for (int k = 0; k < int'($urandom_range(7)); k++) w = {w[6:0], w[7]};
            cur = w;
         end else begin
            cur = 8'($urandom);
         end
         tick(1'b1);
         for (int i = 0; i < 20 + int'($urandom_range(100)); i++) begin
            if ($urandom_range(15) == 0) script.push_back(8'($urandom));
            tick($urandom_range(79) == 0);
         end
      end
      rand_fv = 1'b0;
      noise = 1'b0;
      run(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
